// File: rtl/mul_pkg.sv
// mul_pkg: shared types and helpers for the Booth multiplier issue controller.
package mul_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, ARM, RUN} mul_issue_state_e;

    // RUN cycles allowed before giving up on the multiplier's done flag
    function automatic int timeout_limit(input int data_width);
        return data_width / 2 + 2;
    endfunction

endpackage

// File: rtl/mul_res_fifo.sv
// mul_res_fifo: synchronous result FIFO with async active-high reset and full/empty/count.
module mul_res_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;

    always_comb begin
        wr_d  = i_push ? wr_q + 1'b1 : wr_q;
        rd_d  = i_pop ? rd_q + 1'b1 : rd_q;
        cnt_d = cnt_q + {{AW{1'b0}}, i_push} - {{AW{1'b0}}, i_pop};
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (i_push) mem_q[wr_q] <= i_data;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign o_data  = mem_q[rd_q];
    assign o_count = cnt_q;
    assign o_full  = cnt_q == (AW + 1)'(DEPTH);
    assign o_empty = cnt_q == '0;

    assert property (@(posedge i_clk) disable iff (i_rst) !(i_push && o_full));
    assert property (@(posedge i_clk) disable iff (i_rst) !(i_pop && o_empty));

endmodule

// File: rtl/mul_booth_issue_ctrl.sv
// mul_booth_issue_ctrl: sequences mul_2nbit_booth through load/run and queues products.
// Optional RUN watchdog and sticky o_timeout enabled by MUL_ISSUE_TIMEOUT_EN.
module mul_booth_issue_ctrl
    import mul_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int RES_DEPTH  = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_op_valid,
    output logic                    o_op_ready,
    input  logic [DATA_WIDTH-1:0]   i_op_x,
    input  logic [DATA_WIDTH-1:0]   i_op_y,
    output logic                    o_mul_rst_n,
    output logic [DATA_WIDTH-1:0]   o_mul_num_x,
    output logic [DATA_WIDTH-1:0]   o_mul_num_y,
    input  logic                    i_mul_end,
    input  logic                    i_mul_cry,
    input  logic [2*DATA_WIDTH-1:0] i_mul_res,
    output logic                    o_res_valid,
    input  logic                    i_res_ready,
    output logic [2*DATA_WIDTH-1:0] o_res,
    output logic                    o_res_cry,
`ifdef MUL_ISSUE_TIMEOUT_EN
    output logic                    o_timeout,
`endif
    output logic                    o_busy
);
    localparam int RW = 2 * DATA_WIDTH + 1;
    localparam int CW = $clog2(RES_DEPTH) + 1;

    mul_issue_state_e        state_q, state_d;
    logic [DATA_WIDTH-1:0]   x_q, x_d, y_q, y_d;
    logic                    op_fire, push, pop, tmo;
    logic [RW-1:0]           push_data, fifo_data;
    logic                    fifo_full, fifo_empty;
    logic [CW-1:0]           fifo_cnt;

    assign op_fire   = i_op_valid && o_op_ready;
    assign push      = (state_q == RUN) && (i_mul_end || tmo);
    assign pop       = i_res_ready && !fifo_empty;
    // a timeout pushes an all-zero result with a clear carry
    assign push_data = i_mul_end ? {i_mul_cry, i_mul_res} : '0;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    always_comb begin
        state_d = (state_q == IDLE) ? (op_fire ? LOAD : IDLE) :
                  (state_q == LOAD) ? ARM :
                  (state_q == ARM)  ? RUN :
                  (push ? IDLE : RUN);
        x_d     = op_fire ? i_op_x : x_q;
        y_d     = op_fire ? i_op_y : y_q;
    end

    always_comb begin
        o_op_ready  = !i_rst && (state_q == IDLE) && (fifo_cnt < CW'(RES_DEPTH));
        o_mul_rst_n = !i_rst && (state_q != LOAD);
        o_busy      = state_q != IDLE;
    end

    assign o_mul_num_x = x_q;
    assign o_mul_num_y = y_q;
    assign o_res_valid = !fifo_empty;
    assign {o_res_cry, o_res} = fifo_data;

`ifdef MUL_ISSUE_TIMEOUT_EN
    localparam int LIM = timeout_limit(DATA_WIDTH);
    localparam int TW  = $clog2(LIM) + 1;

    logic [TW-1:0] run_cnt_q, run_cnt_d;
    logic          timeout_q, timeout_d;

    assign tmo       = (state_q == RUN) && !i_mul_end && (run_cnt_q == TW'(LIM - 1));
    assign run_cnt_d = (state_q == RUN) ? run_cnt_q + 1'b1 : '0;
    assign timeout_d = timeout_q || tmo;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            run_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            run_cnt_q <= run_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_timeout = timeout_q;
`else
    assign tmo = 1'b0;
`endif

    mul_res_fifo #(
        .WIDTH (RW),
        .DEPTH (RES_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (push),
        .i_data  (push_data),
        .i_pop   (pop),
        .o_data  (fifo_data),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_count (fifo_cnt)
    );

    assert property (@(posedge i_clk) disable iff (i_rst) !(push && fifo_full));

endmodule
